// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: window base, register offsets, ID constant,
// funct3 load/store encodings and the DUTY register layout. The CPU top
// imports this package too.
package mmio_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;
    localparam logic [7:0]  OFF_MICROS = 8'hF0;
    localparam logic [7:0]  OFF_MILLIS = 8'hF4;
    localparam logic [7:0]  OFF_DUTY   = 8'hF8;
    localparam logic [7:0]  OFF_ID     = 8'hFC;
    localparam logic [31:0] MMIO_ID    = 32'h4D4D494F;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [7:0] blue;
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] led;
    } duty_t;

    // Defined encoding with natural alignment; unsigned forms exist only for loads.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lane,
                                       input logic is_load);
        case (f3)
            F3_B:    access_ok = 1'b1;
            F3_BU:   access_ok = is_load;
            F3_H:    access_ok = ~lane[0];
            F3_HU:   access_ok = is_load & ~lane[0];
            F3_W:    access_ok = (lane == 2'b00);
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_pwm_channel.sv
// One active-low PWM channel.
// Ports: clk, reset (sync, active-high), pwm_cnt (shared 8-bit counter),
//        pwm_wrap (counter == 255), duty (live duty byte), pad (registered, 0 = lit).
module pwm_channel (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pwm_cnt,
    input  logic       pwm_wrap,
    input  logic [7:0] duty,
    output logic       pad
);

    logic [7:0] shadow;

    // Shadow reloads only at the period boundary so a period never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= 8'd0;
            pad    <= 1'b1;
        end else begin
            if (pwm_wrap) begin
                shadow <= duty;
            end
            pad <= ~(pwm_cnt < shadow);
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral block: MICROS/MILLIS timers, a DUTY register
// driving four PWM pads, and an ID word, in the 0xFFFFFFxx window.
// Ports: clk, reset (sync, active-high), funct3, dmem_wren, dmem_address,
//        dmem_data_in (CPU side); dmem_data_out, mmio_sel (registered read
//        path); led, red, green, blue (active-low PWM pads).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      funct3,
    input  logic            dmem_wren,
    input  logic [XLEN-1:0] dmem_address,
    input  logic [XLEN-1:0] dmem_data_in,
    output logic [XLEN-1:0] dmem_data_out,
    output logic            mmio_sel,
    output logic            led,
    output logic            red,
    output logic            green,
    output logic            blue
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000000;
    localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_W     = 10;

    logic            hit;
    logic [7:0]      offset;
    logic [1:0]      lane;

    assign hit    = (dmem_address[31:8] == MMIO_BASE);
    assign offset = {dmem_address[7:2], 2'b00};
    assign lane   = dmem_address[1:0];

    // Microsecond tick and the two free-running time counters.
    logic [PRESC_W-1:0] presc;
    logic               us_tick;
    logic [MS_W-1:0]    ms_cnt;
    logic [XLEN-1:0]    micros;
    logic [XLEN-1:0]    millis;

    assign us_tick = (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc  <= '0;
            ms_cnt <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            presc <= us_tick ? '0 : presc + PRESC_W'(1);
            if (us_tick) begin
                micros <= micros + 32'd1;
                if (ms_cnt == MS_W'(999)) begin
                    ms_cnt <= '0;
                    millis <= millis + 32'd1;
                end else begin
                    ms_cnt <= ms_cnt + MS_W'(1);
                end
            end
        end
    end

    // DUTY write: byte enables from width/lane, data replicated across lanes.
    duty_t           duty;
    logic [3:0]      wr_be;
    logic [XLEN-1:0] wr_data;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = dmem_data_in;
        case (funct3)
            F3_B:    wr_data = {4{dmem_data_in[7:0]}};
            F3_H:    wr_data = {2{dmem_data_in[15:0]}};
            default: wr_data = dmem_data_in;
        endcase
        if (dmem_wren && hit && (offset == OFF_DUTY) && access_ok(funct3, lane, 1'b0)) begin
            case (funct3)
                F3_B:    wr_be = 4'b0001 << lane;
                F3_H:    wr_be = lane[1] ? 4'b1100 : 4'b0011;
                default: wr_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    duty[8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read path: select word, shift lane down, then extend per funct3.
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] rd_value;

    always_comb begin
        case (offset)
            OFF_MICROS: rd_word = micros;
            OFF_MILLIS: rd_word = millis;
            OFF_DUTY:   rd_word = duty;
            OFF_ID:     rd_word = MMIO_ID;
            default:    rd_word = '0;
        endcase
        rd_shift = rd_word >> {lane, 3'b000};
        rd_value = '0;
        if (access_ok(funct3, lane, 1'b1)) begin
            case (funct3)
                F3_B:    rd_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
                F3_BU:   rd_value = {24'h000000, rd_shift[7:0]};
                F3_H:    rd_value = {{16{rd_shift[15]}}, rd_shift[15:0]};
                F3_HU:   rd_value = {16'h0000, rd_shift[15:0]};
                default: rd_value = rd_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_data_out <= '0;
            mmio_sel      <= 1'b0;
        end else begin
            dmem_data_out <= hit ? rd_value : '0;
            mmio_sel      <= hit;
        end
    end

    // Shared PWM period counter; wrap marks the reload point for all channels.
    logic [7:0] pwm_cnt;
    logic       pwm_wrap;

    assign pwm_wrap = (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    pwm_channel u_led   (.clk(clk), .reset(reset), .pwm_cnt(pwm_cnt), .pwm_wrap(pwm_wrap),
                         .duty(duty.led),   .pad(led));
    pwm_channel u_red   (.clk(clk), .reset(reset), .pwm_cnt(pwm_cnt), .pwm_wrap(pwm_wrap),
                         .duty(duty.red),   .pad(red));
    pwm_channel u_green (.clk(clk), .reset(reset), .pwm_cnt(pwm_cnt), .pwm_wrap(pwm_wrap),
                         .duty(duty.green), .pad(green));
    pwm_channel u_blue  (.clk(clk), .reset(reset), .pwm_cnt(pwm_cnt), .pwm_wrap(pwm_wrap),
                         .duty(duty.blue),  .pad(blue));

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: a driver pushes expected read
// responses, a monitor pops and compares one cycle later.
module tb_mmio_responder;

    localparam int unsigned CLK_HZ = 2000000;
    localparam int unsigned DIV    = CLK_HZ / 1000000;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [2:0]  funct3       = 3'b000;
    logic        dmem_wren    = 1'b0;
    logic [31:0] dmem_address = 32'd0;
    logic [31:0] dmem_data_in = 32'd0;
    logic [31:0] dmem_data_out;
    logic        mmio_sel;
    logic        led, red, green, blue;

    always #5 clk = ~clk;

    mmio_responder #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_out(dmem_data_out), .mmio_sel(mmio_sel),
        .led(led), .red(red), .green(green), .blue(blue)
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [32:0] exp_q[$];
    string       tag_q[$];
    logic        issue = 1'b0;

    // Reference state: elapsed cycles since reset, DUTY bytes, MICROS offset.
    int unsigned cyc = 0;
    logic [7:0]  m_duty [4];
    logic [31:0] micros_bias = 32'd0;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model_read(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0]     w;
        logic [31:0]     v;
        int              size;
        int              lane;
        logic            sgn;
        longint unsigned m;
        longint unsigned x;
        if (a[31:8] != 24'hFFFFFF) return 33'd0;
        case (a[7:2])
            6'h3C:   w = 32'(cyc / DIV) + micros_bias;
            6'h3D:   w = 32'(cyc / (DIV * 1000));
            6'h3E:   w = {m_duty[3], m_duty[2], m_duty[1], m_duty[0]};
            6'h3F:   w = 32'h4D4D494F;
            default: w = 32'd0;
        endcase
        sgn = 1'b0;
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd4:    size = 1;
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd5:    size = 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        lane = int'(a[1:0]);
        if (size == 0 || (lane % size) != 0) return {1'b1, 32'd0};
        if (size == 4) return {1'b1, w};
        m = 64'd1 << (8 * size);
        x = (64'(w) >> (8 * lane)) % m;
        v = 32'(x);
        if (sgn && x >= m / 2) v = v - 32'(m);
        return {1'b1, v};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int          size;
        int          lane;
        logic [31:0] t;
        if (a[31:8] != 24'hFFFFFF || a[7:2] != 6'h3E) return;
        case (f3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        lane = int'(a[1:0]);
        if (size == 0 || (lane % size) != 0) return;
        for (int i = 0; i < size; i++) begin
            t = d >> (8 * i);
            m_duty[lane + i] = t[7:0];
        end
    endtask

    // One bus cycle; expected response taken before the write updates the model.
    task automatic xact(input logic [31:0] a, input logic [2:0] f3, input logic wr,
                        input logic [31:0] d, input string tag);
        @(negedge clk);
        dmem_address = a; funct3 = f3; dmem_wren = wr; dmem_data_in = d; issue = 1'b1;
        exp_q.push_back(model_read(a, f3));
        tag_q.push_back(tag);
        if (wr) model_write(a, f3, d);
    endtask

    // Directed cycle with a literal expected response.
    task automatic xact_exp(input logic [31:0] a, input logic [2:0] f3, input logic wr,
                            input logic [31:0] d, input string tag, input logic [32:0] exp);
        @(negedge clk);
        dmem_address = a; funct3 = f3; dmem_wren = wr; dmem_data_in = d; issue = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (wr) model_write(a, f3, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dmem_address = 32'd0; funct3 = 3'd0; dmem_wren = 1'b0; dmem_data_in = 32'd0;
            issue = 1'b0;
        end
    endtask

    // Reset with a competing DUTY store; reset must win.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; issue = 1'b0;
        dmem_address = 32'hFFFFFFF8; funct3 = 3'd2; dmem_wren = 1'b1; dmem_data_in = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) m_duty[i] = 8'd0;
        micros_bias = 32'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_out", {mmio_sel, dmem_data_out}, 33'd0);
            check("rst_pads", {29'd0, led, red, green, blue}, 33'hF);
        end
        reset = 1'b0; dmem_wren = 1'b0; dmem_address = 32'd0;
    endtask

    // Lit cycles over one full period must equal each duty byte.
    task automatic pwm_measure(input string tag);
        int lit [4];
        for (int i = 0; i < 4; i++) lit[i] = 0;
        idle(520);
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (!led)   lit[0]++;
            if (!red)   lit[1]++;
            if (!green) lit[2]++;
            if (!blue)  lit[3]++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pwm_%s_ch%0d", tag, i), 33'(lit[i]), 33'(m_duty[i]));
        end
    endtask

    // Monitor: every issued cycle yields one registered response after the edge.
    initial begin
        logic iss;
        logic [32:0] e;
        string t;
        forever begin
            @(posedge clk);
            iss = issue;
            #1;
            if (iss) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL monitor: response %h with no expected entry",
                             {mmio_sel, dmem_data_out});
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check(t, {mmio_sel, dmem_data_out}, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;
        int          lit;

        for (int i = 0; i < 4; i++) m_duty[i] = 8'd0;
        do_reset(3);
        idle(1);
        check("pads_after_rst", {29'd0, led, red, green, blue}, 33'hF);

        xact_exp(32'hFFFFFFFC, 3'd2, 1'b0, 0, "id", {1'b1, 32'h4D4D494F});
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "duty_rst", {1'b1, 32'h0});

        xact(32'hFFFFFFF8, 3'd2, 1'b1, 32'h80FF4000, "sw_duty");
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "lw_duty", {1'b1, 32'h80FF4000});
        idle(1);
        pwm_measure("dir");

        xact(32'hFFFFFFF9, 3'd0, 1'b1, 32'h0000007F, "sb_duty");
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "lw_after_sb", {1'b1, 32'h80FF7F00});
        xact_exp(32'hFFFFFFFB, 3'd0, 1'b0, 0, "lb",  {1'b1, 32'hFFFFFF80});
        xact_exp(32'hFFFFFFFB, 3'd4, 1'b0, 0, "lbu", {1'b1, 32'h00000080});
        xact_exp(32'hFFFFFFFA, 3'd1, 1'b0, 0, "lh",  {1'b1, 32'hFFFF80FF});

        xact(32'hFFFFFFF9, 3'd1, 1'b1, 32'h00001234, "sh_misalign");
        xact(32'hFFFFFFFA, 3'd2, 1'b1, 32'h11223344, "sw_misalign");
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "duty_unchanged", {1'b1, 32'h80FF7F00});
        xact_exp(32'h00001000, 3'd2, 1'b0, 0, "out_of_window", 33'd0);
        xact_exp(32'hFFFFFFF9, 3'd2, 1'b0, 0, "lw_misalign", {1'b1, 32'h0});
        xact_exp(32'hFFFFFFF8, 3'd3, 1'b0, 0, "ld_undef", {1'b1, 32'h0});
        // Same-cycle read of DUTY sees the pre-write value.
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b1, 32'hA5A5A5A5, "rdw", {1'b1, 32'h80FF7F00});
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "rdw_after", {1'b1, 32'hA5A5A5A5});

        idle(1);
        while (cyc < 2000) idle(1);
        xact(32'hFFFFFFF0, 3'd2, 1'b0, 0, "micros");
        xact(32'hFFFFFFF4, 3'd2, 1'b0, 0, "millis");
        idle(1);

        // Push MICROS to its top value and let it wrap.
        dut.micros = 32'hFFFFFFFF;
        micros_bias = 32'hFFFFFFFF - 32'(cyc / DIV);
        idle(1);
        xact_exp(32'hFFFFFFF0, 3'd2, 1'b0, 0, "micros_wrap", {1'b1, 32'h0});
        xact(32'hFFFFFFF4, 3'd2, 1'b0, 0, "millis_after_wrap");
        xact(32'hFFFFFFF8, 3'd2, 1'b0, 0, "duty_after_wrap");

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      a = 32'hFFFFFFF8 | 32'($urandom_range(0, 3));
            else if (r < 8) a = {24'hFFFFFF, 8'($urandom_range(0, 255))};
            else            a = 32'h00001000 + 32'($urandom_range(0, 255));
            f3 = 3'($urandom_range(0, 7));
            xact(a, f3, 1'($urandom_range(0, 1)), $urandom(), $sformatf("rand%0d", n));
        end
        idle(2);
        pwm_measure("rand");

        xact(32'hFFFFFFF8, 3'd2, 1'b1, 32'hFFFFFFFF, "sw_ff");
        idle(700);
        do_reset(1);
        idle(1);
        check("pads_post_midrst", {29'd0, led, red, green, blue}, 33'hF);
        xact_exp(32'hFFFFFFF8, 3'd2, 1'b0, 0, "duty_post_midrst", {1'b1, 32'h0});
        xact(32'hFFFFFFF8, 3'd2, 1'b1, 32'hFFFFFFFF, "sw_ff_post");
        lit = 0;
        for (int c = 0; c < 200; c++) begin
            idle(1);
            if (!led || !red || !green || !blue) lit++;
        end
        check("no_partial_pulse", 33'(lit), 33'd0);
        pwm_measure("post_rst");

        idle(3);
        check("queue_drain", 33'(exp_q.size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
